// File: rtl/mem_responder.sv
// Memory-side responder for the CPU MAR/MDR bus: one request at a time, driving async SRAM strobes.
// Latency: accept edge k -> R high in cycle k+WAIT_CYCLES+1 (WAIT_CYCLES strobe cycles, then R cycle).
// Backpressure: a held MEM_EN is serviced once; HOLD waits for MEM_EN=0 before accepting again.
// Optional MMIO_HEX_EN: MMIO_ADDR maps to Switches (read) / HEX_out (write) with no SRAM strobes.
module mem_responder #(
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 20,
  parameter logic [15:0] MMIO_ADDR   = 16'hFFFF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               MEM_EN,
  input  logic               WE,
  input  logic [15:0]        ADDR,
  input  logic [15:0]        Data_from_CPU,
  output logic [15:0]        Data_to_CPU,
  output logic               R,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic [15:0]        SRAM_DQ_out,
  output logic               SRAM_DQ_oe,
  input  logic [15:0]        SRAM_DQ_in,
  input  logic [15:0]        Switches,
  output logic [15:0]        HEX_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        we_q, we_nxt;
  logic        mmio_q, mmio_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [15:0] data_q, data_nxt;
  logic [15:0] rd_q;
  logic        ce_n_q, oe_n_q, we_n_q, dq_oe_q, r_q;
  logic        ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe_nxt, r_nxt;
  logic        sram_cyc;
  logic        is_mmio;
  logic [15:0] rd_src;

`ifdef MMIO_HEX_EN
  assign is_mmio = (ADDR == MMIO_ADDR);
  assign rd_src  = mmio_q ? Switches : SRAM_DQ_in;
`else
  // I/O word is ordinary SRAM in this build; the switch inputs are left unused.
  logic unused_io;
  assign unused_io = ^{Switches, MMIO_ADDR};
  assign is_mmio   = 1'b0;
  assign rd_src    = SRAM_DQ_in;
`endif

  // Next-state, request latch and next strobe values (strobes are decoded from the next state so they can be registered).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = we_q;
    mmio_nxt  = mmio_q;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    case (state)
      IDLE: begin
        if (MEM_EN) begin
          state_nxt = ACCESS;
          cnt_nxt   = 4'(WAIT_CYCLES - 1);
          we_nxt    = WE;
          mmio_nxt  = is_mmio;
          addr_nxt  = ADDR;
          data_nxt  = Data_from_CPU;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = HOLD;
      HOLD:    if (!MEM_EN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    sram_cyc  = (state_nxt == ACCESS) && !mmio_nxt;
    ce_n_nxt  = !sram_cyc;
    oe_n_nxt  = !(sram_cyc && !we_nxt);
    we_n_nxt  = !(sram_cyc && we_nxt);
    dq_oe_nxt = sram_cyc && we_nxt;
    r_nxt     = (state_nxt == RESP);
  end

  // State, request latch and registered strobes; reset aborts any access in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      mmio_q  <= 1'b0;
      addr_q  <= 16'd0;
      data_q  <= 16'd0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      we_q    <= we_nxt;
      mmio_q  <= mmio_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      ce_n_q  <= ce_n_nxt;
      oe_n_q  <= oe_n_nxt;
      we_n_q  <= we_n_nxt;
      dq_oe_q <= dq_oe_nxt;
      r_q     <= r_nxt;
    end
  end

  // Read data is captured on the last strobe cycle and held until the next read completes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                      rd_q <= 16'd0;
    else if (state == ACCESS && cnt == 4'd0 && !we_q) rd_q <= rd_src;
  end

`ifdef MMIO_HEX_EN
  logic [15:0] hex_q;
  // The hex display register loads from the latched write data during the response cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                            hex_q <= 16'd0;
    else if (state == RESP && we_q && mmio_q) hex_q <= data_q;
  end
  assign HEX_out = hex_q;
`else
  assign HEX_out = 16'd0;
`endif

  assign Data_to_CPU = rd_q;
  assign R           = r_q;
  assign SRAM_ADDR   = {{(SRAM_AW-16){1'b0}}, addr_q};
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_DQ_out = data_q;
  assign SRAM_DQ_oe  = dq_oe_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: SRAM behavioural model, shadow memory and read-data scoreboard.
// Latency, strobe widths, single-R, reset abort and MMIO decode (follows MMIO_HEX_EN) are checked.
// Requests are held until R, then dropped for exactly one cycle before the next request.
module tb_mem_responder;

  localparam int W = 2;

  logic        Clk, Reset, MEM_EN, WE;
  logic [15:0] ADDR, Data_from_CPU, Data_to_CPU;
  logic        R;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_oe;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in, Switches, HEX_out;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] sram    [0:65535];
  logic [15:0] exp_mem [0:65535];
  logic [15:0] sb [$];

  mem_responder #(.WAIT_CYCLES(W), .SRAM_AW(20), .MMIO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .MEM_EN(MEM_EN), .WE(WE), .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .R(R),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
    .SRAM_DQ_in(SRAM_DQ_in), .Switches(Switches), .HEX_out(HEX_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Asynchronous SRAM model
  assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR[15:0]] : 16'h0000;
  always @(posedge Clk) if (!SRAM_CE_N && !SRAM_WE_N) sram[SRAM_ADDR[15:0]] = SRAM_DQ_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdat,
                           input logic drop_early, input int hold_n);
    int r_cyc, ce_cnt, oe_cnt, we_cnt, bad_addr, bad_dq, extra_r;
    logic io;
    logic [15:0] exp_rd;
    r_cyc = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; bad_addr = 0; bad_dq = 0; extra_r = 0;
    io = 1'b0;
`ifdef MMIO_HEX_EN
    io = (addr == 16'hFFFF);
`endif
    @(posedge Clk); #1;
    MEM_EN = 1'b1; WE = we; ADDR = addr; Data_from_CPU = wdat;
    exp_rd = io ? Switches : exp_mem[addr];
    if (!we) sb.push_back(exp_rd);
    else if (!io) exp_mem[addr] = wdat;
    // accept edge; scramble inputs to show the latched copies are used
    @(posedge Clk); #1;
    WE = ~we; ADDR = ~addr; Data_from_CPU = ~wdat;
    for (int c = 1; c <= 40 && r_cyc == 0; c++) begin
      @(negedge Clk);
      if (!SRAM_CE_N) begin
        ce_cnt++;
        if (SRAM_ADDR != {4'h0, addr}) bad_addr++;
      end
      if (!SRAM_OE_N) oe_cnt++;
      if (!SRAM_WE_N) begin
        we_cnt++;
        if (!SRAM_DQ_oe || SRAM_DQ_out != wdat) bad_dq++;
      end
      if (R) r_cyc = c;
      if (drop_early && c == 1) MEM_EN = 1'b0;
    end
    chk("latency", r_cyc, W + 1);
    chk("ce_cycles", ce_cnt, io ? 0 : W);
    chk(we ? "we_cycles" : "oe_cycles", we ? we_cnt : oe_cnt, io ? 0 : W);
    chk("cross_strobe", we ? oe_cnt : we_cnt, 0);
    chk("sram_addr", bad_addr, 0);
    if (we) chk("dq_out", bad_dq, 0);
    if (!we) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else if (r_cyc != 0) chk("rd_data", Data_to_CPU, sb.pop_front());
      else void'(sb.pop_front());
    end
    for (int c = 0; c < hold_n; c++) begin
      @(negedge Clk);
      if (R) extra_r++;
    end
    chk("single_r", extra_r, 0);
    @(posedge Clk); #1;
    MEM_EN = 1'b0;
    if (!we) begin
      @(negedge Clk);
      chk("rd_hold", Data_to_CPU, exp_rd);
    end
  endtask

  initial begin
    int r_seen;
    Reset = 1'b1; MEM_EN = 1'b0; WE = 1'b0; ADDR = 16'h0; Data_from_CPU = 16'h0;
    Switches = 16'h5A5A;
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 16'h0000; exp_mem[i] = 16'h0000;
    end
    sram[16'h0050] = 16'hBEEF; exp_mem[16'h0050] = 16'hBEEF;
    sram[16'h0001] = 16'hC0DE; exp_mem[16'h0001] = 16'hC0DE;

    // mid-cycle asynchronous reset
    #23 Reset = 1'b0;
    #1;
    chk("rst_r", R, 0);
    chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
    chk("rst_dq_oe", SRAM_DQ_oe, 0);
    chk("rst_dout", Data_to_CPU, 16'h0);
    chk("rst_hex", HEX_out, 16'h0);
    chk("rst_addr", SRAM_ADDR, 20'h0);
    @(negedge Clk); Reset = 1'b1;

    do_access(1'b1, 16'h0040, 16'h1234, 1'b0, 0);
    do_access(1'b0, 16'h0040, 16'h0000, 1'b0, 0);
    do_access(1'b0, 16'h0050, 16'h0000, 1'b0, 10);   // held 10 cycles after R
    do_access(1'b1, 16'h0041, 16'hA55A, 1'b0, 3);    // starts after one low cycle
    do_access(1'b0, 16'h0041, 16'h0000, 1'b0, 0);

    // I/O word: MMIO when enabled, ordinary SRAM otherwise
    do_access(1'b1, 16'hFFFF, 16'h00A5, 1'b0, 0);
`ifdef MMIO_HEX_EN
    chk("hex_out", HEX_out, 16'h00A5);
`else
    chk("hex_out", HEX_out, 16'h0000);
`endif
    do_access(1'b0, 16'hFFFF, 16'h0000, 1'b0, 0);

    // MEM_EN dropped mid-access: write completes, readback confirms it
    do_access(1'b1, 16'h0060, 16'h9999, 1'b1, 2);
    do_access(1'b0, 16'h0060, 16'h0000, 1'b0, 0);

    // reset during the ACCESS phase of a write
    @(posedge Clk); #1;
    MEM_EN = 1'b1; WE = 1'b1; ADDR = 16'h0002; Data_from_CPU = 16'h7777;
    @(posedge Clk);
    @(negedge Clk);
    chk("pre_rst_we_n", SRAM_WE_N, 0);
    #2 Reset = 1'b0;
    #1;
    chk("abort_we_n", SRAM_WE_N, 1);
    chk("abort_ce_n", SRAM_CE_N, 1);
    chk("abort_dq_oe", SRAM_DQ_oe, 0);
    chk("abort_dout", Data_to_CPU, 16'h0);
    chk("abort_hex", HEX_out, 16'h0);
    MEM_EN = 1'b0;
    r_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      if (R) r_seen++;
    end
    Reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      if (R) r_seen++;
    end
    chk("abort_no_r", r_seen, 0);
    do_access(1'b0, 16'h0001, 16'h0000, 1'b0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
